wb_write_arbiter: RTL and testbench



---
 rtl/wb_write_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Writeback arbiter owning the single register-file write port.
//            Loads always win; losing ALU results wait in an in-order queue.
// Revision : 1.0  initial release
// ============================================================================
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  input  logic [4:0]             ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   WE3,
  output logic [4:0]             A3,
  output logic [XLEN-1:0]        WD3,
  output logic [31:0]            pend_mask,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       qrd_q   [DEPTH];
  logic [4:0]       qrd_d   [DEPTH];
  logic [XLEN-1:0]  qdata_q [DEPTH];
  logic [XLEN-1:0]  qdata_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [XLEN-1:0]  wd3_q, wd3_d;

  logic             alu_acc, q_empty, push, pop, sel_valid;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;

  always_comb begin
    alu_ready = !rst && (count_q < CNT_W'(DEPTH));
    alu_acc   = alu_valid && alu_ready;
    q_empty   = (count_q == '0);
    pop       = !ld_valid && !q_empty;
    // An accepted ALU result bypasses the queue only if nothing else wants the port
    push      = alu_acc && (ld_valid || !q_empty);

    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (ld_valid) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rd;
      sel_data  = ld_data;
    end else if (!q_empty) begin
      sel_valid = 1'b1;
      sel_rd    = qrd_q[head_q];
      sel_data  = qdata_q[head_q];
    end else if (alu_acc) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end

    we3_d = sel_valid && (sel_rd != 5'd0);
    a3_d  = we3_d ? sel_rd : 5'd0;
    wd3_d = we3_d ? sel_data : '0;

    qrd_d   = qrd_q;
    qdata_d = qdata_q;
    if (push) begin
      qrd_d[tail_q]   = alu_rd;
      qdata_d[tail_q] = alu_data;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    logic [PTR_W-1:0] offs;
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - head_q;
      if (({1'b0, offs} < count_q) && (qrd_q[i] != 5'd0))
        pend_mask = pend_mask | (32'd1 << qrd_q[i]);
    end
    if (we3_q)
      pend_mask = pend_mask | (32'd1 << a3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qrd_q[i]   <= '0;
        qdata_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      qrd_q   <= qrd_d;
      qdata_q <= qdata_d;
    end
  end

  assign WE3     = we3_q;
  assign A3      = a3_q;
  assign WD3     = wd3_q;
  assign q_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Purpose  : Randomized and directed bench for wb_write_arbiter against a
//            queue-based reference model of the writeback rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_write_arbiter;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst, ld_valid, alu_valid, alu_ready, WE3;
  logic [4:0]             ld_rd, alu_rd, A3;
  logic [XLEN-1:0]        ld_data, alu_data, WD3;
  logic [31:0]            pend_mask;
  logic [$clog2(DEPTH):0] q_count;

  int n_vec = 0;
  int n_err = 0;

  ent_t            mq[$];
  logic            m_we;
  logic [4:0]      m_a3;
  logic [XLEN-1:0] m_wd;
  logic            last_acc;

  wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .WE3(WE3), .A3(A3), .WD3(WD3), .pend_mask(pend_mask), .q_count(q_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].rd != 5'd0) p[mq[i].rd] = 1'b1;
    if (m_we) p[m_a3] = 1'b1;
    return p;
  endfunction

  // Called at a falling edge: drive, check ready, advance the model, clock, check outputs.
  task automatic step(input logic r, input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ld,
                      input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad);
    logic            er, have;
    logic [4:0]      srd;
    logic [XLEN-1:0] sd;
    ent_t            e;
    rst = r; ld_valid = lv; ld_rd = lr; ld_data = ld;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    #1;
    er = !r && (mq.size() < DEPTH);
    chk("alu_ready", alu_ready, er);
    last_acc = av && er;
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_a3 = '0; m_wd = '0;
    end else begin
      have = 1'b0; srd = '0; sd = '0;
      if (lv) begin
        have = 1'b1; srd = lr; sd = ld;
        if (last_acc) mq.push_back({ar, ad});
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        have = 1'b1; srd = e.rd; sd = e.d;
        if (last_acc) mq.push_back({ar, ad});
      end else if (last_acc) begin
        have = 1'b1; srd = ar; sd = ad;
      end
      m_we = have && (srd != 5'd0);
      m_a3 = m_we ? srd : 5'd0;
      m_wd = m_we ? sd : '0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("WE3", WE3, m_we);
    chk("A3", A3, m_a3);
    chk("WD3", WD3, m_wd);
    chk("q_count", q_count, mq.size());
    chk("pend_mask", pend_mask, model_pend());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    logic [4:0] fq [3];
    int k;
    rst = 1'b1; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    m_we = 1'b0; m_a3 = '0; m_wd = '0; last_acc = 1'b0;
    @(negedge clk);

    // Reset held with both producers active
    repeat (3) step(1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
    chk("rst_we3", WE3, 0);
    chk("rst_pend", pend_mask, 0);
    idle();
    chk("ready_after_rst", alu_ready, 1);

    // ALU only
    step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd5, 32'h11);
    chk("alu_we3", WE3, 1);
    chk("alu_a3", A3, 5);
    chk("alu_wd3", WD3, 32'h11);
    chk("alu_pend", pend_mask, 32'h20);
    idle();
    chk("alu_we3_off", WE3, 0);
    chk("alu_pend_off", pend_mask, 0);

    // Load/ALU conflict
    step(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
    chk("conf_a3", A3, 3);
    chk("conf_wd3", WD3, 32'hAA);
    chk("conf_qcnt", q_count, 1);
    chk("conf_pend4", pend_mask[4], 1);
    idle();
    chk("conf2_a3", A3, 4);
    chk("conf2_wd3", WD3, 32'hBB);

    // Full queue under a 4-cycle load burst
    fq[0] = 5'd6; fq[1] = 5'd7; fq[2] = 5'd8;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 5'(20 + i), 32'(i), k < 3, (k < 3) ? fq[k] : 5'd0, 32'h100 + 32'(k));
      if (last_acc) k++;
      if (i == 1) chk("full_ready", alu_ready, 0);
    end
    chk("full_accepted", k, 2);
    for (int i = 0; i < 10 && k < 3; i++) begin
      step(1'b0, 1'b0, 5'd0, '0, 1'b1, fq[k], 32'h100 + 32'(k));
      if (last_acc) k++;
    end
    chk("full_accept_all", k, 3);
    repeat (3) idle();

    // Destination x0
    step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFF);
    chk("x0_we3", WE3, 0);
    chk("x0_pend", pend_mask, 0);
    chk("x0_ready", alu_ready, 1);

    // Reset with two queued entries
    step(1'b0, 1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA0);
    step(1'b0, 1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC0);
    chk("flush_pre_qcnt", q_count, 2);
    step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    repeat (3) idle();
    chk("flush_qcnt", q_count, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 40, 5'($urandom), $urandom,
           $urandom_range(0, 99) < 70, 5'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
